stream_recorder: RTL and testbench

- Byte-stream sink: captures a valid/ready byte stream into an internal 1024-entry RAM, then replays the captured bytes in order on a valid/ready output.
- It is the write-side counterpart of the ROM-backed byte streamers. It records DUT output streams, and those records are later dumped for comparison against preloaded ROM images.
- Single clock domain; capture and dump never overlap.

---
 rtl/stream_recorder_pkg.sv | 18 +
 rtl/stream_recorder_if.sv | 29 ++
 rtl/stream_recorder_byte_ram.sv | 25 ++
 rtl/stream_recorder.sv | 147 ++++++++++++++
 tb/tb_stream_recorder.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_recorder_pkg.sv
// Shared types and constants for the stream recorder.
package stream_recorder_pkg;

  localparam int DATA_WIDTH_DEF   = 7;  // MSB index of a data byte
  localparam int CURSOR_WIDTH_DEF = 9;  // MSB index of the RAM address

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DUMP    = 2'd2
  } state_t;

  // Number of RAM entries addressed by a cursor whose MSB index is cursor_width.
  function automatic int depth_of(input int cursor_width);
    return 2 ** (cursor_width + 1);
  endfunction

endpackage

// File: rtl/stream_recorder_if.sv
// Byte-stream input and output channels of the stream recorder.
//
// Handshake: a byte moves when valid && ready are both high at a rising clk
// edge. The valid side holds valid and data stable until that edge; ready
// may change freely and is never a precondition for raising valid.
interface stream_recorder_if
  import stream_recorder_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic                in_valid;
  logic [DATA_WIDTH:0] in_data;
  logic                in_ready;
  logic                out_valid;
  logic [DATA_WIDTH:0] out_data;
  logic                out_ready;

  // Producer of the captured stream and consumer of the replayed stream.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // The recorder itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/stream_recorder_byte_ram.sv
// Single-port byte RAM with a registered read; contents are never reset.
module byte_ram
  import stream_recorder_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int CURSOR_WIDTH = CURSOR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [CURSOR_WIDTH:0] addr,
  input  logic [DATA_WIDTH:0]   wdata,
  output logic [DATA_WIDTH:0]   rdata
);
  localparam int DEPTH = depth_of(CURSOR_WIDTH);

  logic [DATA_WIDTH:0] mem [DEPTH];

  // Write on we; read data for addr appears one cycle later (read-first).
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end
endmodule

// File: rtl/stream_recorder.sv
// Records a valid/ready byte stream into RAM and replays it in order on demand.
module stream_recorder
  import stream_recorder_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int CURSOR_WIDTH = CURSOR_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    arm,
  input  logic                    stop,
  input  logic                    dump,
  stream_recorder_if.slave        bus,
  output logic [CURSOR_WIDTH+1:0] count,
  output logic                    full,
  output logic                    busy,
  output state_t                  state
);
  localparam int                    DEPTH   = depth_of(CURSOR_WIDTH);
  localparam logic [CURSOR_WIDTH+1:0] DEPTH_C = DEPTH[CURSOR_WIDTH+1:0];

  logic [CURSOR_WIDTH+1:0] rd_ptr;      // next address to read during DUMP
  logic                    rd_pend;     // a read was issued last cycle; rdata is valid now
  logic                    hold_valid;  // second skid slot behind the output register
  logic [DATA_WIDTH:0]     hold_data;
  logic                    out_valid_q;
  logic [DATA_WIDTH:0]     out_data_q;

  logic                    ram_we;
  logic [CURSOR_WIDTH:0]   ram_addr;
  logic [DATA_WIDTH:0]     rdata;

  logic                    in_fire;
  logic                    out_fire;
  logic                    rd_issue;
  logic                    last_fire;
  logic [1:0]              occ;

  assign bus.in_ready  = (state == CAPTURE) && (count < DEPTH_C);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = out_valid_q && bus.out_ready;

  assign full = (count == DEPTH_C);
  assign busy = (state != IDLE);

  // Capture writes at the fill level; dump reads at the replay pointer.
  assign ram_we   = in_fire;
  assign ram_addr = (state == CAPTURE) ? count[CURSOR_WIDTH:0] : rd_ptr[CURSOR_WIDTH:0];

  // A read may issue only if, after this cycle's pop, its result still has a
  // slot: bytes in the output register, the hold register and in flight
  // from the RAM are all counted against the two skid entries.
  always_comb begin
    occ       = {1'b0, out_valid_q} + {1'b0, hold_valid} + {1'b0, rd_pend};
    rd_issue  = (state == DUMP) && (rd_ptr < count) &&
                ((occ - {1'b0, out_fire}) < 2'd2);
    last_fire = (state == DUMP) && out_fire && !hold_valid && !rd_pend &&
                (rd_ptr == count);
  end

  byte_ram #(
    .DATA_WIDTH   (DATA_WIDTH),
    .CURSOR_WIDTH (CURSOR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (bus.in_data),
    .rdata (rdata)
  );

  // Control FSM, fill counter, replay pointer and the two-entry output skid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      rd_ptr      <= '0;
      rd_pend     <= 1'b0;
      hold_valid  <= 1'b0;
      hold_data   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arm) begin
            state <= CAPTURE;
            count <= '0;
          end else if (dump && (count != '0)) begin
            state       <= DUMP;
            rd_ptr      <= '0;
            rd_pend     <= 1'b0;
            hold_valid  <= 1'b0;
            out_valid_q <= 1'b0;
          end
        end

        CAPTURE: begin
          if (in_fire) begin
            count <= count + 1'b1;
          end
          // The byte taken alongside stop, or the one that fills the RAM,
          // is still stored and counted above.
          if (stop || (in_fire && (count == DEPTH_C - 1'b1))) begin
            state <= IDLE;
          end
        end

        DUMP: begin
          rd_pend <= rd_issue;
          if (rd_issue) begin
            rd_ptr <= rd_ptr + 1'b1;
          end

          if (!out_valid_q || out_fire) begin
            // Output slot frees: refill from hold first, then from the RAM.
            if (hold_valid) begin
              out_valid_q <= 1'b1;
              out_data_q  <= hold_data;
              hold_valid  <= rd_pend;
              hold_data   <= rdata;
            end else begin
              out_valid_q <= rd_pend;
              if (rd_pend) begin
                out_data_q <= rdata;
              end
            end
          end else if (rd_pend) begin
            // Output stalled: park the arriving byte in the hold slot.
            hold_valid <= 1'b1;
            hold_data  <= rdata;
          end

          if (last_fire) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stream_recorder.sv
// Bench for stream_recorder: table of single-cycle control vectors, directed
// capture/dump sequences and randomized rounds against a queue-based model.
module tb_stream_recorder;
  import stream_recorder_pkg::*;

  localparam int DW    = 7;
  localparam int CW    = 9;
  localparam int DEPTH = 1024;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          arm;
  logic          stop;
  logic          dump;
  logic [CW+1:0] count;
  logic          full;
  logic          busy;
  state_t        state;

  stream_recorder_if #(.DATA_WIDTH(DW)) bus();

  stream_recorder #(
    .DATA_WIDTH   (DW),
    .CURSOR_WIDTH (CW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .arm   (arm),
    .stop  (stop),
    .dump  (dump),
    .bus   (bus),
    .count (count),
    .full  (full),
    .busy  (busy),
    .state (state)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q[$];   // bytes the recorder should currently hold, in order
  logic [7:0] src_q[$];   // bytes to offer during the next capture

  typedef struct {
    logic          arm;
    logic          stop;
    logic          dump;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          exp_in_ready;
    logic          exp_busy;
    logic [CW+1:0] exp_count;
  } vec_t;

  vec_t vecs[11];

  localparam logic O = 1'b0;
  localparam logic I = 1'b1;

  function automatic vec_t mk(input logic a, input logic s, input logic d,
                              input logic v, input logic [7:0] dat,
                              input logic er, input logic eb, input int ec);
    vec_t r;
    r.arm          = a;
    r.stop         = s;
    r.dump         = d;
    r.in_valid     = v;
    r.in_data      = dat;
    r.exp_in_ready = er;
    r.exp_busy     = eb;
    r.exp_count    = ec[CW+1:0];
    return r;
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Arm, offer src_q bytes until n_accept are taken or max_offers cycles pass,
  // then end the capture (with stop alongside the last byte, or a stop pulse).
  task automatic capture(input int n_accept, input int max_offers,
                         input int valid_pct, input bit stop_on_last);
    int   offers;
    bit   cap;
    bit   v;
    bit   er;
    bit   st;
    offers = 0;
    cap    = 1'b1;
    arm = 1'b1;
    step();
    arm = 1'b0;
    exp_q.delete();
    check("arm_count", 32'(count), 32'd0);
    check("arm_busy", 32'(busy), 32'd1);
    while (exp_q.size() < n_accept && offers < max_offers) begin
      v  = ($urandom_range(0, 99) < valid_pct);
      er = cap && (exp_q.size() < DEPTH);
      bus.in_valid = v;
      bus.in_data  = (exp_q.size() < src_q.size()) ? src_q[exp_q.size()] : 8'h00;
      check("in_ready", 32'(bus.in_ready), 32'(er));
      st   = stop_on_last && v && er && (exp_q.size() == n_accept - 1);
      stop = st;
      if (v && er) exp_q.push_back(bus.in_data);
      if (st || exp_q.size() == DEPTH) cap = 1'b0;
      step();
      offers++;
    end
    bus.in_valid = 1'b0;
    stop         = 1'b0;
    if (cap) begin
      stop = 1'b1;
      step();
      stop = 1'b0;
    end
    check("cap_busy", 32'(busy), 32'd0);
    check("cap_state", 32'(state), 32'(IDLE));
    check("cap_count", 32'(count), 32'(exp_q.size()));
    check("cap_full", 32'(full), 32'(exp_q.size() == DEPTH));
    check("cap_in_ready_idle", 32'(bus.in_ready), 32'd0);
    step();
    check("idle_busy_hold", 32'(busy), 32'd0);
  endtask

  // Pulse dump and consume the replay. mode 0: ready always high,
  // 1: ready pattern 1,0,0,1,0,1 repeating, 2: random ready.
  // abort_after >= 0 stops consuming after that many handshakes.
  task automatic dump_run(input int mode, input int abort_after);
    int          idx;
    int          t;
    int          guard;
    int          n;
    bit          first_seen;
    bit          prev_stall;
    bit          r;
    bit          aborted;
    logic [7:0]  prev_data;
    logic [5:0]  pat;
    idx        = 0;
    t          = 0;
    guard      = 0;
    n          = exp_q.size();
    first_seen = 1'b0;
    prev_stall = 1'b0;
    aborted    = 1'b0;
    prev_data  = 8'h00;
    pat        = 6'b101001;
    dump = 1'b1;
    step();
    dump = 1'b0;
    while (idx < n && guard < 5000) begin
      if (abort_after >= 0 && idx == abort_after) begin
        aborted = 1'b1;
        break;
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = pat[t % 6];
        default: r = 1'($urandom_range(0, 1));
      endcase
      bus.out_ready = r;
      if (prev_stall) check("stall_valid", 32'(bus.out_valid), 32'd1);
      if (bus.out_valid) begin
        if (!first_seen) begin
          first_seen = 1'b1;
          check("first_valid_latency", 32'(t), 32'd2);
        end
        check("out_data", 32'(bus.out_data), 32'(exp_q[idx]));
        if (prev_stall) check("stall_data", 32'(bus.out_data), 32'(prev_data));
        prev_stall = !r;
        prev_data  = bus.out_data;
        if (r) idx++;
      end else begin
        prev_stall = 1'b0;
      end
      step();
      t++;
      guard++;
    end
    if (guard >= 5000) check("dump_timeout", 32'(idx), 32'(n));
    if (!aborted) begin
      check("dump_done_valid", 32'(bus.out_valid), 32'd0);
      check("dump_done_busy", 32'(busy), 32'd0);
      check("dump_count_kept", 32'(count), 32'(exp_q.size()));
      step();
      check("dump_quiet_valid", 32'(bus.out_valid), 32'd0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst           = 1'b1;
    arm           = 1'b0;
    stop          = 1'b0;
    dump          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    step();
    step();
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    rst = 1'b0;

    // Single-cycle control vectors: ignore rules and arm priority.
    vecs[0]  = mk(O, O, O, O, 8'h00, O, O, 0);
    vecs[1]  = mk(O, O, I, O, 8'h00, O, O, 0);   // dump with nothing captured
    vecs[2]  = mk(I, O, I, O, 8'h00, I, I, 0);   // arm beats dump
    vecs[3]  = mk(O, O, O, I, 8'hA5, I, I, 1);
    vecs[4]  = mk(O, O, I, I, 8'h5A, I, I, 2);   // dump ignored in capture
    vecs[5]  = mk(I, O, O, O, 8'h00, I, I, 2);   // arm ignored in capture
    vecs[6]  = mk(O, O, O, O, 8'h00, I, I, 2);
    vecs[7]  = mk(O, I, O, I, 8'h77, O, O, 3);   // byte alongside stop counts
    vecs[8]  = mk(O, I, O, O, 8'h00, O, O, 3);   // stop in idle is harmless
    vecs[9]  = mk(I, O, O, O, 8'h00, I, I, 0);   // re-arm clears count
    vecs[10] = mk(O, I, O, O, 8'h00, O, O, 0);
    for (int i = 0; i < 11; i++) begin
      arm           = vecs[i].arm;
      stop          = vecs[i].stop;
      dump          = vecs[i].dump;
      bus.in_valid  = vecs[i].in_valid;
      bus.in_data   = vecs[i].in_data;
      step();
      check($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'(vecs[i].exp_in_ready));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'd0);
    end
    arm = 1'b0; stop = 1'b0; dump = 1'b0; bus.in_valid = 1'b0;
    exp_q.delete();

    // Three bytes, continuous valid, then replay with steady and toggling ready.
    src_q = '{8'h11, 8'h22, 8'h33};
    capture(3, 100, 100, 1'b0);
    dump_run(0, -1);
    dump_run(1, -1);

    // Overfill: 1100 offered bytes, only 1024 kept; full replay.
    src_q.delete();
    for (int i = 0; i < 1100; i++) src_q.push_back(8'(i % 256));
    capture(1100, 1100, 100, 1'b0);
    check("fill_count", 32'(count), 32'd1024);
    check("fill_full", 32'(full), 32'd1);
    dump_run(0, -1);

    // Stop on the same cycle as the fifth byte, then arm+dump together.
    src_q.delete();
    for (int i = 0; i < 8; i++) src_q.push_back(8'($urandom_range(0, 255)));
    capture(5, 1000, 70, 1'b1);
    check("stop_last_count", 32'(count), 32'd5);
    arm  = 1'b1;
    dump = 1'b1;
    step();
    arm  = 1'b0;
    dump = 1'b0;
    check("armdump_state", 32'(state), 32'(CAPTURE));
    check("armdump_count", 32'(count), 32'd0);
    check("armdump_out_valid", 32'(bus.out_valid), 32'd0);
    exp_q.delete();
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("armdump_stop_busy", 32'(busy), 32'd0);

    // Randomized rounds: random length, valid duty and consumer ready.
    for (int r = 0; r < 6; r++) begin
      src_q.delete();
      for (int i = 0; i < 64; i++) src_q.push_back(8'($urandom_range(0, 255)));
      capture($urandom_range(1, 50), 1000, $urandom_range(30, 100), 1'($urandom_range(0, 1)));
      dump_run(2, -1);
    end

    // Reset in the middle of a replay.
    src_q.delete();
    for (int i = 0; i < 10; i++) src_q.push_back(8'($urandom_range(0, 255)));
    capture(10, 100, 100, 1'b0);
    dump_run(0, 4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    exp_q.delete();
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_count", 32'(count), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    dump = 1'b1;
    step();
    dump = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("empty_dump_busy", 32'(busy), 32'd0);
      check("empty_dump_valid", 32'(bus.out_valid), 32'd0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Bound on the whole run in case the DUT never finishes a phase.
  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
